// File: rtl/mul_datapath.sv
// mul_datapath: operand/product datapath for the repeated-addition multiplier.
// Holds multiplicand A, down-counting multiplier B and product accumulator P.
// The controller drives the strobes. eqz reports B == 0 so the controller can
// end the accumulate loop.
// Optional feature: define MUL_DP_OVF_EN to build the sticky accumulate-overflow
// flag. Without it, ovf is tied low and P wraps silently mod 2^PW.
// PW must be >= W; A is zero-extended into the adder.
module mul_datapath #(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_in,
  input  logic          LdA,
  input  logic          LdB,
  input  logic          LdP,
  input  logic          clrP,
  input  logic          decB,
  output logic          eqz,
  output logic [PW-1:0] product,
  output logic          ovf
);

  localparam logic [W-1:0]  B_ZERO = {W{1'b0}};
  localparam logic [W-1:0]  B_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};

  // Zero-extend the W-bit multiplicand to the accumulator width.
  function automatic logic [PW-1:0] widen_a(input logic [W-1:0] a_val);
    logic [PW-1:0] r;
    r = P_ZERO;
    r[W-1:0] = a_val;
    return r;
  endfunction

  logic [W-1:0]  a_r;
  logic [W-1:0]  a_nxt_s;
  logic [W-1:0]  b_r;
  logic [W-1:0]  b_nxt_s;
  logic [PW-1:0] p_r;
  logic [PW-1:0] p_nxt_s;
  logic          b_nz_s;
  logic          acc_ok_s;

  // eqz depends only on the B register. This keeps the controller's loop test
  // free of any path from the strobes.
  assign eqz     = (b_r == B_ZERO);
  assign product = p_r;

  // Both guards use the pre-edge value of B. The add in the B: 1->0 cycle still
  // lands. Strobes issued after B reaches zero do nothing.
  always_comb begin
    b_nz_s   = (b_r != B_ZERO);
    acc_ok_s = 1'b0;
    if (!clrP && LdP && b_nz_s) begin
      acc_ok_s = 1'b1;
    end else begin
      acc_ok_s = 1'b0;
    end
  end

  // Next value of A: load from the operand bus, otherwise hold.
  always_comb begin
    a_nxt_s = a_r;
    if (LdA) begin
      a_nxt_s = data_in;
    end else begin
      a_nxt_s = a_r;
    end
  end

  // Next value of B: a load beats a decrement. A decrement at zero is ignored,
  // so B never wraps to all-ones.
  always_comb begin
    b_nxt_s = b_r;
    if (LdB) begin
      b_nxt_s = data_in;
    end else if (decB && b_nz_s) begin
      b_nxt_s = b_r - B_ONE;
    end else begin
      b_nxt_s = b_r;
    end
  end

`ifdef MUL_DP_OVF_EN
  logic [PW:0] sum_s;
  logic        ovf_r;
  logic        ovf_nxt_s;

  assign ovf = ovf_r;

  // Next value of P, with a carry bit so an accepted add can detect overflow.
  // A clear beats an accumulate.
  always_comb begin
    sum_s   = {1'b0, p_r} + {1'b0, widen_a(a_r)};
    p_nxt_s = p_r;
    if (clrP) begin
      p_nxt_s = P_ZERO;
    end else if (acc_ok_s) begin
      p_nxt_s = sum_s[PW-1:0];
    end else begin
      p_nxt_s = p_r;
    end
  end

  // Next value of ovf: sticky until clrP. clrP wins over a same-cycle carry.
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (clrP) begin
      ovf_nxt_s = 1'b0;
    end else if (acc_ok_s && sum_s[PW]) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_nxt_s;
    end
  end
`else
  logic [PW-1:0] sum_s;

  assign ovf = 1'b0;

  // Next value of P: a clear beats an accumulate. The PW-bit sum wraps silently.
  always_comb begin
    sum_s   = p_r + widen_a(a_r);
    p_nxt_s = p_r;
    if (clrP) begin
      p_nxt_s = P_ZERO;
    end else if (acc_ok_s) begin
      p_nxt_s = sum_s;
    end else begin
      p_nxt_s = p_r;
    end
  end
`endif

  // A, B and P registers. Reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= B_ZERO;
      b_r <= B_ZERO;
      p_r <= P_ZERO;
    end else begin
      a_r <= a_nxt_s;
      b_r <= b_nxt_s;
      p_r <= p_nxt_s;
    end
  end

endmodule

// File: tb/tb_mul_datapath.sv
// tb_mul_datapath: table-driven directed vectors, multi-cycle multiply
// sequences and randomized strobes. All results are checked against an
// arithmetic reference model of the A/B/P rules.
module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        LdA = 1'b0, LdB = 1'b0, LdP = 1'b0, clrP = 1'b0, decB = 1'b0;
  logic        eqz, ovf, eqz8, ovf8;
  logic [15:0] product;
  logic [7:0]  product8;

  int checks = 0;
  int failures = 0;

  // Reference state (16-bit product instance)
  int m_a, m_b, m_p, m_ovf;

`ifdef MUL_DP_OVF_EN
  localparam bit OVF_BUILT = 1'b1;
`else
  localparam bit OVF_BUILT = 1'b0;
`endif

  mul_datapath #(.W(8), .PW(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .LdA(LdA), .LdB(LdB),
    .LdP(LdP), .clrP(clrP), .decB(decB), .eqz(eqz), .product(product), .ovf(ovf)
  );

  mul_datapath #(.W(8), .PW(8)) dut8 (
    .clk(clk), .rst(rst), .data_in(data_in), .LdA(LdA), .LdB(LdB),
    .LdP(LdP), .clrP(clrP), .decB(decB), .eqz(eqz8), .product(product8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply one cycle of strobes, advance the model, and compare the 16-bit instance.
  task automatic step(input logic r, input logic lda, input logic ldb,
                      input logic ldp, input logic clrp, input logic decb,
                      input logic [7:0] din);
    int na, nb, np, novf, sum;
    rst = r; LdA = lda; LdB = ldb; LdP = ldp; clrP = clrp; decB = decb; data_in = din;
    na = m_a; nb = m_b; np = m_p; novf = m_ovf;
    if (r) begin
      na = 0; nb = 0; np = 0; novf = 0;
    end else begin
      if (lda) na = din;
      if (ldb) nb = din;
      else if (decb && m_b != 0) nb = m_b - 1;
      if (clrp) begin
        np = 0; novf = 0;
      end else if (ldp && m_b != 0) begin
        sum = m_p + m_a;
        if (OVF_BUILT && sum >= 65536) novf = 1;
        np = sum % 65536;
      end
    end
    m_a = na; m_b = nb; m_p = np; m_ovf = novf;
    @(posedge clk);
    #1;
    chk("model_a", dut.a_r, m_a);
    chk("model_b", dut.b_r, m_b);
    chk("model_p", product, m_p);
    chk("model_eqz", eqz, (m_b == 0));
    chk("model_ovf", ovf, m_ovf);
  endtask

  typedef struct {
    logic       r, lda, ldb, ldp, clrp, decb;
    logic [7:0] din;
    int         ea, eb, ep;
    logic       eeqz;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    int k;
    // Basic 5x3 multiply
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd0,   0, 0,  0, 1'b1};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'd5,   5, 0,  0, 1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 8'd3,   5, 3,  0, 1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   5, 2,  5, 1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   5, 1, 10, 1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   5, 0, 15, 1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   5, 0, 15, 1'b1};
    // A=7, B=0: strobes are no-ops
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'd7,   7, 0, 15, 1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'd0,   7, 0,  0, 1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   7, 0,  0, 1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   7, 0,  0, 1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   7, 0,  0, 1'b1};
    // LdB beats decB; clrP beats LdP
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 8'd9,   7, 9,  0, 1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 8'd40, 40, 9,  0, 1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'd0,  40, 9, 40, 1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 8'd0,  40, 9,  0, 1'b0};
    // Reset in the middle of a 6x4 multiply
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'd6,   6, 9,  0, 1'b0};
    vecs[17] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 8'd4,   6, 4,  0, 1'b0};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   6, 3,  6, 1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   6, 2, 12, 1'b0};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   0, 0,  0, 1'b1};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 8'd0,   0, 0,  0, 1'b1};

    m_a = 0; m_b = 0; m_p = 0; m_ovf = 0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].r, vecs[i].lda, vecs[i].ldb, vecs[i].ldp, vecs[i].clrp,
           vecs[i].decb, vecs[i].din);
      chk($sformatf("vec%0d_a", i), dut.a_r, vecs[i].ea);
      chk($sformatf("vec%0d_b", i), dut.b_r, vecs[i].eb);
      chk($sformatf("vec%0d_p", i), product, vecs[i].ep);
      chk($sformatf("vec%0d_eqz", i), eqz, vecs[i].eeqz);
      chk($sformatf("vec%0d_ovf", i), ovf, 0);
    end

    // 20x20 on the 8-bit accumulator: 20*13 = 260 is the first carry-out
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20);
    k = 0;
    while (!eqz && k < 300) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
      k++;
      chk($sformatf("m20_p8_k%0d", k), product8, (20 * k) % 256);
      chk($sformatf("m20_ovf8_k%0d", k), ovf8, (OVF_BUILT && k >= 13) ? 1 : 0);
    end
    chk("m20_acc_count", k, 20);
    chk("m20_product8", product8, 144);
    chk("m20_product16", product, 400);
    chk("m20_eqz8", eqz8, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    chk("m20_clr_ovf8", ovf8, 0);
    chk("m20_clr_p8", product8, 0);

    // 255x255 on the 16-bit accumulator
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    k = 0;
    while (!eqz && k < 400) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
      k++;
    end
    chk("m255_acc_count", k, 255);
    chk("m255_product", product, 65025);
    chk("m255_ovf", ovf, 0);
    chk("m255_eqz", eqz, 1);

    // Randomized strobes against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
